// File: rtl/isqrt_rr_arbiter.sv
// isqrt_rr_arbiter: shares one pipelined isqrt unit among N_REQ requesters.
// Each cycle it grants at most one request, round-robin, and forwards that
// operand to the isqrt x-port. An in-order tag FIFO remembers which requester
// issued each in-flight op. Returning results are steered back to that requester.
// Optional build macro: ISQRT_ARB_PRIO0_EN gives requester 0 strict priority.
// Requesters 1..N_REQ-1 then round-robin among themselves.
module isqrt_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_vld,
  input  logic [N_REQ*32-1:0] req_x,
  output logic [N_REQ-1:0]   req_rdy,
  output logic [N_REQ-1:0]   rsp_vld,
  output logic [15:0]        rsp_y,
  output logic               isqrt_x_vld,
  output logic [31:0]        isqrt_x,
  input  logic               isqrt_y_vld,
  input  logic [15:0]        isqrt_y,
  output logic               busy,
  output logic               err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             eligible;
  logic             found;
  logic             upd_ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cand;
  logic             grant;
  logic             pop;
  logic [ID_W-1:0]  head_id;

  // FIFO pointers wrap mod DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign eligible = (count < CNT_W'(DEPTH));
  assign grant    = rst_n & eligible & found;
  assign head_id  = tag_mem[rd_ptr];
  // An empty FIFO never pops: a stray result is dropped and flagged instead.
  assign pop      = isqrt_y_vld & (count != '0);
  assign busy     = (count != '0);

  // Winner search: first valid requester after the last winner, wrapping.
  always_comb begin
    found   = 1'b0;
    upd_ptr = 1'b0;
    winner  = '0;
    cand    = '0;
`ifdef ISQRT_ARB_PRIO0_EN
    if (req_vld[0]) begin
      // Requester 0 wins outright and leaves the rotation untouched.
      found   = 1'b1;
      winner  = '0;
    end else begin
      // Bit 0 is clear here, so the rotation only ever lands on 1..N_REQ-1.
      for (int k = 1; k <= N_REQ; k++) begin
        cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
        if (!found && req_vld[cand]) begin
          found   = 1'b1;
          upd_ptr = 1'b1;
          winner  = cand;
        end else begin
          found = found;
        end
      end
    end
`else
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_vld[cand]) begin
        found   = 1'b1;
        upd_ptr = 1'b1;
        winner  = cand;
      end else begin
        found = found;
      end
    end
`endif
  end

  // One-hot grant and operand mux toward the isqrt x-port.
  always_comb begin
    req_rdy = '0;
    isqrt_x = 32'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant && (winner == ID_W'(i))) begin
        req_rdy[i] = 1'b1;
        isqrt_x    = req_x[32*i +: 32];
      end else begin
        req_rdy[i] = 1'b0;
      end
    end
    isqrt_x_vld = |req_rdy;
  end

  // Route the returning result to the requester at the FIFO head.
  always_comb begin
    rsp_vld = '0;
    rsp_y   = pop ? isqrt_y : 16'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pop && (head_id == ID_W'(i))) begin
        rsp_vld[i] = 1'b1;
      end else begin
        rsp_vld[i] = 1'b0;
      end
    end
  end

  // Arbitration pointer, FIFO bookkeeping and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= ID_W'(N_REQ - 1);
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (grant && upd_ptr) begin
        rr_ptr <= winner;
      end
      if (grant) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({grant, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (isqrt_y_vld && (count == '0)) begin
        err <= 1'b1;
      end
    end
  end

  // Tag storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_mem[wr_ptr] <= winner;
    end
  end

endmodule
